// File: rtl/lab1_led_pkg.sv
// Shared constants and helpers for the Lab1 LED fader.
package lab1_led_pkg;

  localparam int PWM_BITS_DEF = 8;
  localparam int STEP_DIV_DEF = 196;

  // Brightness endpoint for a target bit: full scale when lit, zero when dark.
  // Returned 32 bits wide; callers truncate to their own PWM width.
  function automatic logic [31:0] endpoint(input logic tgt, input int bits);
    logic [31:0] v_max;
    v_max = (32'd1 << bits) - 32'd1;
    return tgt ? v_max : 32'd0;
  endfunction

endpackage

// File: rtl/lab1_led_fade_channel.sv
// One LED channel: brightness level register with saturating ramp or bypass,
// plus the registered PWM compare that drives the pin.
module lab1_led_fade_channel
  import lab1_led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_target,
  input  logic                i_fade_en,
  input  logic                i_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led,
  output logic                o_at_endpoint
);

  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] w_level_nxt;
  logic [PWM_BITS-1:0] w_endpoint;
  logic                r_led;

  assign w_endpoint = PWM_BITS'(endpoint(i_target, PWM_BITS));

  // Next brightness: bypass jumps to the endpoint, otherwise one saturating step per tick.
  always_comb begin
    w_level_nxt = r_level;
    if (!i_fade_en) begin
      w_level_nxt = w_endpoint;
    end else if (i_tick && i_target && (r_level != MAX)) begin
      w_level_nxt = r_level + PWM_BITS'(1);
    end else if (i_tick && !i_target && (r_level != {PWM_BITS{1'b0}})) begin
      w_level_nxt = r_level - PWM_BITS'(1);
    end else begin
      w_level_nxt = r_level;
    end
  end

  // Brightness level register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= {PWM_BITS{1'b0}};
    end else begin
      r_level <= w_level_nxt;
    end
  end

  // PWM output; full scale is forced solid so there is no one-slot dropout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= 1'b0;
    end else if (r_level == MAX) begin
      r_led <= 1'b1;
    end else begin
      r_led <= (r_level > i_pwm_cnt);
    end
  end

  assign o_led         = r_led;
  assign o_at_endpoint = (r_level == w_endpoint);

endmodule

// File: rtl/lab1_sys_led_fader.sv
// PWM LED fader behind the Lab1 PIO: registers the software pattern, generates
// the shared step tick and PWM counter, and reports when any channel is ramping.
module lab1_sys_led_fader
  import lab1_led_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

  logic [NUM_LEDS-1:0] r_target_q;
  logic [PW-1:0]       r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_busy;
  logic                w_tick;
  logic [NUM_LEDS-1:0] w_led;
  logic [NUM_LEDS-1:0] w_at_endpoint;

  assign w_tick = (r_presc == PRESC_LAST);

  // Capture the software pattern as the per-channel target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_target_q <= {NUM_LEDS{1'b0}};
    end else begin
      r_target_q <= pattern_in;
    end
  end

  // Step prescaler; runs regardless of fade_en so toggling it keeps tick phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= {PW{1'b0}};
    end else if (w_tick) begin
      r_presc <= {PW{1'b0}};
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Free-running PWM counter shared by all channels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= {PWM_BITS{1'b0}};
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  generate
    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
      lab1_led_fade_channel #(
        .PWM_BITS (PWM_BITS)
      ) u_ch (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_target      (r_target_q[g]),
        .i_fade_en     (fade_en),
        .i_tick        (w_tick),
        .i_pwm_cnt     (r_pwm_cnt),
        .o_led         (w_led[g]),
        .o_at_endpoint (w_at_endpoint[g])
      );
    end
  endgenerate

  // Busy whenever any channel is away from its endpoint.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= ~(&w_at_endpoint);
    end
  end

  assign led_out = w_led;
  assign busy    = r_busy;

endmodule
